exec_issue: RTL and testbench
=============================

EXEC_ISSUE -- requirements
Module: exec_issue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 clk  in  1  clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 in_valid / in_ready  in / out  1 / 1  decoded-instruction handshake from decode.
REQ-005 in_alu_ctl  in  3  ALU op: ADD=0, SUB=1, XOR=2, SLL=3, SRA=4, BLT=5, BNE=6.
REQ-006 in_rs1, in_rs2, in_rd  in  5 each  register indices.
REQ-007 in_rs1_val, in_rs2_val, in_imm, in_pc  in  32 each  register-file operands, immediate, instruction PC.
REQ-008 in_use_imm, in_wen  in  1 each  src_b = immediate; writes rd.
REQ-009 flush  in  1  kill the instruction held in stage 1.
REQ-010 wb_wen, wb_rd, wb_data  in  1/5/32  writeback forwarding source.
REQ-011 alu_ctl, src_a, src_b  out  3/32/32  drive the ALU combinationally.
REQ-012 alu_result, alu_hit  in  32/1  ALU outputs, same cycle.
REQ-013 out_valid / out_ready  out / in  1 / 1  result handshake to the memory stage.
REQ-014 out_result, out_rd, out_wen  out  32/5/1  registered result.
REQ-015 redirect_valid, redirect_pc  out  1/32  taken-branch redirect to fetch.

Function
REQ-016 Stage 1 (s1) SHALL hold one instruction: ctl, rs1, rs2, rd, operand values, imm, pc, use_imm, wen, valid.
REQ-017 Stage 2 (s2) SHALL hold one result: result, rd, wen, valid; out_* SHALL come directly from s2 registers.
REQ-018 s1_fire = s1_valid && (!s2_valid || out_ready); in_ready = (!s1_valid || s1_fire) && !flush && !redirect_valid.
REQ-019 in_valid && in_ready SHALL load s1 at the edge; otherwise s1 SHALL hold, or clear its valid on s1_fire.
REQ-020 On s1_fire, s2 SHALL load alu_result, s1 rd, and wen; s2 wen SHALL be forced to 0 for BLT/BNE or rd=0.
REQ-021 out_valid && out_ready without s1_fire SHALL clear s2 valid.
REQ-022 Latency: instruction accepted at edge N appears on out_* after edge N+1 if unstalled; throughput 1 per cycle.
REQ-023 Operand forwarding per source rsX, evaluated every cycle, highest priority first:
  - rsX=0 -> 0.
  - s2_valid && s2_wen && s2_rd=rsX -> s2 result.
  - wb_wen && wb_rd=rsX -> wb_data.
  - otherwise the s1 stored value.
REQ-024 While s1 holds without firing, a wb match per REQ-023 SHALL overwrite the stored s1 operand, so a later wb cycle cannot lose it.
REQ-025 src_a SHALL be forwarded rs1; src_b SHALL be imm if use_imm and ctl not BLT/BNE, else forwarded rs2; alu_ctl = s1 ctl.
REQ-026 redirect_valid SHALL be s1_fire && ctl in {BLT,BNE} && alu_hit (combinational); redirect_pc = s1_pc + s1_imm, mod 2^32.
REQ-027 flush SHALL clear s1 valid at the edge, suppress s1_fire and redirect in that cycle, and leave s2 untouched.
REQ-028 flush and in_valid in the same cycle: in_ready=0, nothing accepted.
REQ-029 Invalid ctl (7) SHALL pass alu_result (0) with the given wen.

Reset
REQ-030 rst SHALL clear s1 valid and s2 valid; out_valid=0, redirect_valid=0, out_wen=0, out_result=0, out_rd=0.
REQ-031 rst SHALL override in_valid, flush, and out_ready in the same cycle; in_ready SHALL be 1 in the first cycle after reset.

Verification
REQ-032 ADD x3=x1(5)+imm(7), use_imm=1, out_ready=1 -> out_valid two edges after accept, out_result=12, out_rd=3, out_wen=1.
REQ-033 Back-to-back: SUB x4=x3-x2 right after REQ-032's instruction (x2=2, stale x3=0) -> src_a=12 via s2 forward, out_result=10.
REQ-034 out_ready=0 for 3 cycles with s1 and s2 full -> in_ready=0, out_* stable; wb_wen x1=9 during the stall -> after release, s1 uses x1=9.
REQ-035 BNE x1(1),x2(2), pc=0x100, imm=0x20 -> redirect_valid for exactly one cycle, redirect_pc=0x120, out_wen=0, in_ready=0 that cycle; BLT -3<2 signed -> taken.
REQ-036 flush with s1 holding ADD and in_valid=1 -> instruction never appears on out_*, new instruction not accepted; s2 content still delivered.
REQ-037 rst asserted mid-stall with both stages full -> next cycle out_valid=0, in_ready=1, redirect_valid=0.

Source files
------------

// File: rtl/exec_issue.sv
// exec_issue: two-stage execute issue block.
// Stage 1 holds one decoded instruction, forwards its operands and drives the
// external ALU. Stage 2 registers the ALU result for the memory stage.
// Taken branches produce a one-cycle redirect to fetch.

module exec_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_alu_ctl,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_pc,
  input  logic        in_use_imm,
  input  logic        in_wen,
  input  logic        flush,
  input  logic        wb_wen,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [2:0]  alu_ctl,
  output logic [31:0] src_a,
  output logic [31:0] src_b,
  input  logic [31:0] alu_result,
  input  logic        alu_hit,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_XOR = 3'd2,
    OP_SLL = 3'd3,
    OP_SRA = 3'd4,
    OP_BLT = 3'd5,
    OP_BNE = 3'd6,
    OP_INV = 3'd7
  } aluOp_e;

  // Stage 1 registers
  logic        s1Valid_q, s1Valid_d;
  aluOp_e      s1Ctl_q, s1Ctl_d;
  logic [4:0]  s1Rs1_q, s1Rs1_d;
  logic [4:0]  s1Rs2_q, s1Rs2_d;
  logic [4:0]  s1Rd_q, s1Rd_d;
  logic [31:0] s1Rs1Val_q, s1Rs1Val_d;
  logic [31:0] s1Rs2Val_q, s1Rs2Val_d;
  logic [31:0] s1Imm_q, s1Imm_d;
  logic [31:0] s1Pc_q, s1Pc_d;
  logic        s1UseImm_q, s1UseImm_d;
  logic        s1Wen_q, s1Wen_d;

  // Stage 2 registers
  logic        s2Valid_q, s2Valid_d;
  logic [31:0] s2Result_q, s2Result_d;
  logic [4:0]  s2Rd_q, s2Rd_d;
  logic        s2Wen_q, s2Wen_d;

  // Combinational control
  logic        isBranch;
  logic        s1Fire;
  logic        accept;
  logic [31:0] fwdA;
  logic [31:0] fwdB;

  assign isBranch       = (s1Ctl_q == OP_BLT) || (s1Ctl_q == OP_BNE);
  assign s1Fire         = s1Valid_q && (!s2Valid_q || out_ready) && !flush;
  assign redirect_valid = s1Fire && isBranch && alu_hit;
  assign redirect_pc    = s1Pc_q + s1Imm_q;
  assign in_ready       = (!s1Valid_q || s1Fire) && !flush && !redirect_valid;
  assign accept         = in_valid && in_ready;

  assign alu_ctl = s1Ctl_q;
  assign src_a   = fwdA;
  assign src_b   = (s1UseImm_q && !isBranch) ? s1Imm_q : fwdB;

  assign out_valid  = s2Valid_q;
  assign out_result = s2Result_q;
  assign out_rd     = s2Rd_q;
  assign out_wen    = s2Wen_q;

  // Operand bypass: x0 reads zero, the younger s2 result beats writeback,
  // and the value captured in stage 1 is the fallback.
  always_comb begin
    fwdA = s1Rs1Val_q;
    if (s1Rs1_q == 5'd0) begin
      fwdA = '0;
    end else if (s2Valid_q && s2Wen_q && (s2Rd_q == s1Rs1_q)) begin
      fwdA = s2Result_q;
    end else if (wb_wen && (wb_rd == s1Rs1_q)) begin
      fwdA = wb_data;
    end

    fwdB = s1Rs2Val_q;
    if (s1Rs2_q == 5'd0) begin
      fwdB = '0;
    end else if (s2Valid_q && s2Wen_q && (s2Rd_q == s1Rs2_q)) begin
      fwdB = s2Result_q;
    end else if (wb_wen && (wb_rd == s1Rs2_q)) begin
      fwdB = wb_data;
    end
  end

  // Stage 1 next state: load on accept, drop on fire or flush, and while
  // stalled latch the bypassed operands so a one-cycle writeback is not lost.
  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1Ctl_d    = s1Ctl_q;
    s1Rs1_d    = s1Rs1_q;
    s1Rs2_d    = s1Rs2_q;
    s1Rd_d     = s1Rd_q;
    s1Rs1Val_d = s1Rs1Val_q;
    s1Rs2Val_d = s1Rs2Val_q;
    s1Imm_d    = s1Imm_q;
    s1Pc_d     = s1Pc_q;
    s1UseImm_d = s1UseImm_q;
    s1Wen_d    = s1Wen_q;
    if (accept) begin
      s1Valid_d  = 1'b1;
      s1Ctl_d    = aluOp_e'(in_alu_ctl);
      s1Rs1_d    = in_rs1;
      s1Rs2_d    = in_rs2;
      s1Rd_d     = in_rd;
      s1Rs1Val_d = in_rs1_val;
      s1Rs2Val_d = in_rs2_val;
      s1Imm_d    = in_imm;
      s1Pc_d     = in_pc;
      s1UseImm_d = in_use_imm;
      s1Wen_d    = in_wen;
    end else if (flush || s1Fire) begin
      s1Valid_d = 1'b0;
    end else if (s1Valid_q) begin
      s1Rs1Val_d = fwdA;
      s1Rs2Val_d = fwdB;
    end
  end

  // Stage 2 next state: capture the ALU result when stage 1 fires, otherwise
  // empty once the memory stage takes the result.
  always_comb begin
    s2Valid_d  = s2Valid_q;
    s2Result_d = s2Result_q;
    s2Rd_d     = s2Rd_q;
    s2Wen_d    = s2Wen_q;
    if (s1Fire) begin
      s2Valid_d  = 1'b1;
      s2Result_d = alu_result;
      s2Rd_d     = s1Rd_q;
      s2Wen_d    = s1Wen_q && !isBranch && (s1Rd_q != 5'd0);
    end else if (s2Valid_q && out_ready) begin
      s2Valid_d = 1'b0;
    end
  end

  // Stage 1 register update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q  <= 1'b0;
      s1Ctl_q    <= OP_ADD;
      s1Rs1_q    <= '0;
      s1Rs2_q    <= '0;
      s1Rd_q     <= '0;
      s1Rs1Val_q <= '0;
      s1Rs2Val_q <= '0;
      s1Imm_q    <= '0;
      s1Pc_q     <= '0;
      s1UseImm_q <= 1'b0;
      s1Wen_q    <= 1'b0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1Ctl_q    <= s1Ctl_d;
      s1Rs1_q    <= s1Rs1_d;
      s1Rs2_q    <= s1Rs2_d;
      s1Rd_q     <= s1Rd_d;
      s1Rs1Val_q <= s1Rs1Val_d;
      s1Rs2Val_q <= s1Rs2Val_d;
      s1Imm_q    <= s1Imm_d;
      s1Pc_q     <= s1Pc_d;
      s1UseImm_q <= s1UseImm_d;
      s1Wen_q    <= s1Wen_d;
    end
  end

  // Stage 2 register update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s2Valid_q  <= 1'b0;
      s2Result_q <= '0;
      s2Rd_q     <= '0;
      s2Wen_q    <= 1'b0;
    end else begin
      s2Valid_q  <= s2Valid_d;
      s2Result_q <= s2Result_d;
      s2Rd_q     <= s2Rd_d;
      s2Wen_q    <= s2Wen_d;
    end
  end

endmodule

// File: tb/tb_exec_issue.sv
// tb_exec_issue: self-checking bench for exec_issue.
// Directed scenarios cover reset, latency, bypassing, stalls, branches and
// flush; a randomized run checks results against in-order execution over an
// architectural register file.

module tb_exec_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_alu_ctl;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  logic [31:0] in_imm;
  logic [31:0] in_pc;
  logic        in_use_imm;
  logic        in_wen;
  logic        flush;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [2:0]  alu_ctl;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic        alu_hit;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int errors;
  int checks;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        wen;
  } expEntry_t;

  expEntry_t   expQ[$];
  logic [31:0] archRf[32];
  logic [31:0] physRf[32];

  exec_issue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_ctl(in_alu_ctl),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_pc(in_pc),
    .in_use_imm(in_use_imm), .in_wen(in_wen), .flush(flush),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .alu_ctl(alu_ctl), .src_a(src_a), .src_b(src_b),
    .alu_result(alu_result), .alu_hit(alu_hit),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_wen(out_wen),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: what the instruction means arithmetically
  function automatic logic [31:0] aluRef(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (ctl)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a ^ b;
      3'd3:    return a << sh;
      3'd4:    return 32'($signed(a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  // Branch condition: BLT is a signed compare, BNE an inequality
  function automatic logic hitRef(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b);
    if (ctl == 3'd5) return $signed(a) < $signed(b);
    if (ctl == 3'd6) return a != b;
    return 1'b0;
  endfunction

  // The external ALU the block drives, answering in the same cycle
  always_comb begin
    alu_result = aluRef(alu_ctl, src_a, src_b);
    alu_hit    = hitRef(alu_ctl, src_a, src_b);
  end

  // Present one decoded instruction on the input bus
  task automatic applyStimulus(input logic [2:0] ctl, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [31:0] v1, input logic [31:0] v2,
                               input logic [31:0] imm, input logic [31:0] pc,
                               input logic useImm, input logic wen);
    in_alu_ctl = ctl;  in_rs1 = rs1;  in_rs2 = rs2;  in_rd = rd;
    in_rs1_val = v1;   in_rs2_val = v2;
    in_imm = imm;      in_pc = pc;
    in_use_imm = useImm;  in_wen = wen;
  endtask

  // Park every input in a quiet state
  task automatic idleInputs();
    in_valid = 1'b0;  flush = 1'b0;  out_ready = 1'b1;
    wb_wen = 1'b0;  wb_rd = 5'd0;  wb_data = 32'd0;
    applyStimulus(3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // Reset overrides traffic and leaves both stages empty
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;  in_valid = 1'b1;  flush = 1'b1;  out_ready = 1'b0;
    applyStimulus(3'd0, 5'd1, 5'd0, 5'd3, 32'd5, 32'd0, 32'd7, 32'd0, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;  in_valid = 1'b0;  flush = 1'b0;  out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_wen !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_wen: got %b expected 0", out_wen); end
    checks++; if (out_result !== 32'd0) begin errors++; $display("[TB] FAIL reset_out_result: got %h expected 0", out_result); end
    checks++; if (out_rd !== 5'd0) begin errors++; $display("[TB] FAIL reset_out_rd: got %0d expected 0", out_rd); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_redirect: got %b expected 0", redirect_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_no_phantom: got out_valid %b expected 0", out_valid); end
  endtask

  // Single ADD with immediate: two-edge latency to out_*
  task automatic test_add();
    @(negedge clk);
    applyStimulus(3'd0, 5'd1, 5'd0, 5'd3, 32'd5, 32'd0, 32'd7, 32'h0, 1'b1, 1'b1);
    in_valid = 1'b1;  out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL add_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_early_valid: got %b expected 0", out_valid); end
    checks++; if ({alu_ctl, src_a, src_b} !== {3'd0, 32'd5, 32'd7}) begin errors++; $display("[TB] FAIL add_alu_drive: got ctl %0d a %h b %h expected 0 5 7", alu_ctl, src_a, src_b); end
    @(negedge clk); #1;
    checks++; if ({out_valid, out_result, out_rd, out_wen} !== {1'b1, 32'd12, 5'd3, 1'b1}) begin errors++; $display("[TB] FAIL add_result: got v%b %h rd%0d wen%b expected v1 0000000c rd3 wen1", out_valid, out_result, out_rd, out_wen); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_drain: got %b expected 0", out_valid); end
  endtask

  // SUB right behind ADD takes its rs1 from stage 2
  task automatic test_back_to_back();
    @(negedge clk);
    applyStimulus(3'd0, 5'd1, 5'd0, 5'd3, 32'd5, 32'd0, 32'd7, 32'h0, 1'b1, 1'b1);
    in_valid = 1'b1;  out_ready = 1'b1;
    @(negedge clk);
    applyStimulus(3'd1, 5'd3, 5'd2, 5'd4, 32'd0, 32'd2, 32'd0, 32'h4, 1'b0, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if ({out_valid, out_result} !== {1'b1, 32'd12}) begin errors++; $display("[TB] FAIL b2b_first: got v%b %h expected v1 0000000c", out_valid, out_result); end
    checks++; if ({src_a, src_b} !== {32'd12, 32'd2}) begin errors++; $display("[TB] FAIL b2b_forward: got a %h b %h expected 0000000c 00000002", src_a, src_b); end
    @(negedge clk); #1;
    checks++; if ({out_valid, out_result, out_rd} !== {1'b1, 32'd10, 5'd4}) begin errors++; $display("[TB] FAIL b2b_second: got v%b %h rd%0d expected v1 0000000a rd4", out_valid, out_result, out_rd); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: got %b expected 0", out_valid); end
  endtask

  // Three-cycle back-pressure with a writeback to x1 in the middle
  task automatic test_stall();
    @(negedge clk);
    applyStimulus(3'd0, 5'd6, 5'd0, 5'd5, 32'd0, 32'd0, 32'd100, 32'h0, 1'b1, 1'b1);
    in_valid = 1'b1;  out_ready = 1'b0;
    @(negedge clk);
    applyStimulus(3'd0, 5'd1, 5'd0, 5'd7, 32'd3, 32'd0, 32'd10, 32'h4, 1'b1, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_fill_ready: got %b expected 1", in_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      wb_wen = (c == 1);  wb_rd = 5'd1;  wb_data = 32'd9;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready c%0d: got %b expected 0", c, in_ready); end
      checks++; if ({out_valid, out_result, out_rd, out_wen} !== {1'b1, 32'd100, 5'd5, 1'b1}) begin errors++; $display("[TB] FAIL stall_out_hold c%0d: got v%b %h rd%0d wen%b expected v1 00000064 rd5 wen1", c, out_valid, out_result, out_rd, out_wen); end
      if (c > 0) begin
        checks++; if (src_a !== 32'd9) begin errors++; $display("[TB] FAIL stall_wb_operand c%0d: got %h expected 00000009", c, src_a); end
      end
    end
    @(negedge clk);
    wb_wen = 1'b0;  out_ready = 1'b1;
    #1;
    checks++; if ({in_ready, src_a} !== {1'b1, 32'd9}) begin errors++; $display("[TB] FAIL stall_release: got ready %b a %h expected 1 00000009", in_ready, src_a); end
    @(negedge clk); #1;
    checks++; if ({out_valid, out_result, out_rd} !== {1'b1, 32'd19, 5'd7}) begin errors++; $display("[TB] FAIL stall_result: got v%b %h rd%0d expected v1 00000013 rd7", out_valid, out_result, out_rd); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_drain: got %b expected 0", out_valid); end
  endtask

  // Taken BNE, taken signed BLT with pc wrap, and a not-taken BNE
  task automatic test_branch();
    @(negedge clk);
    applyStimulus(3'd6, 5'd1, 5'd2, 5'd5, 32'd1, 32'd2, 32'h20, 32'h100, 1'b1, 1'b1);
    in_valid = 1'b1;  out_ready = 1'b1;
    @(negedge clk);
    applyStimulus(3'd0, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'd1, 32'h104, 1'b1, 1'b1);
    #1;
    checks++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'h120}) begin errors++; $display("[TB] FAIL bne_redirect: got v%b pc %h expected v1 00000120", redirect_valid, redirect_pc); end
    checks++; if ({in_ready, src_b} !== {1'b0, 32'd2}) begin errors++; $display("[TB] FAIL bne_ready_srcb: got ready %b b %h expected 0 00000002", in_ready, src_b); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if ({redirect_valid, out_valid, out_wen} !== 3'b010) begin errors++; $display("[TB] FAIL bne_after: got redir %b v %b wen %b expected 0 1 0", redirect_valid, out_valid, out_wen); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bne_no_accept: got %b expected 0", out_valid); end
    applyStimulus(3'd5, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFD, 32'd2, 32'h20, 32'hFFFFFFF0, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'h10}) begin errors++; $display("[TB] FAIL blt_redirect: got v%b pc %h expected v1 00000010", redirect_valid, redirect_pc); end
    @(negedge clk);
    applyStimulus(3'd6, 5'd1, 5'd2, 5'd0, 32'd4, 32'd4, 32'h40, 32'h200, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if ({redirect_valid, in_ready} !== 2'b01) begin errors++; $display("[TB] FAIL bne_not_taken: got redir %b ready %b expected 0 1", redirect_valid, in_ready); end
    repeat (2) @(negedge clk);
  endtask

  // Flush kills stage 1 and blocks the new instruction; stage 2 still drains
  task automatic test_flush();
    @(negedge clk);
    applyStimulus(3'd0, 5'd0, 5'd0, 5'd8, 32'd77, 32'd0, 32'h55, 32'h0, 1'b1, 1'b1);
    in_valid = 1'b1;  out_ready = 1'b0;
    @(negedge clk);
    applyStimulus(3'd0, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'h66, 32'h4, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(3'd0, 5'd0, 5'd0, 5'd10, 32'd0, 32'd0, 32'h77, 32'h8, 1'b1, 1'b1);
    flush = 1'b1;
    #1;
    checks++; if ({in_ready, redirect_valid} !== 2'b00) begin errors++; $display("[TB] FAIL flush_ready: got ready %b redir %b expected 0 0", in_ready, redirect_valid); end
    @(negedge clk);
    flush = 1'b0;  in_valid = 1'b0;  out_ready = 1'b1;
    #1;
    checks++; if ({out_valid, out_result, out_rd} !== {1'b1, 32'h55, 5'd8}) begin errors++; $display("[TB] FAIL flush_s2_kept: got v%b %h rd%0d expected v1 00000055 rd8", out_valid, out_result, out_rd); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_killed c%0d: got out_valid %b result %h expected 0", c, out_valid, out_result); end
    end
  endtask

  // Reset in the middle of a full stall empties everything
  task automatic test_reset_midstall();
    @(negedge clk);
    applyStimulus(3'd0, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd1, 32'h0, 1'b1, 1'b1);
    in_valid = 1'b1;  out_ready = 1'b0;
    @(negedge clk);
    applyStimulus(3'd6, 5'd1, 5'd0, 5'd2, 32'd0, 32'd0, 32'd2, 32'h4, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("[TB] FAIL midstall_full: got v%b ready %b expected 1 0", out_valid, in_ready); end
    @(negedge clk);
    rst = 1'b1;  in_valid = 1'b1;  out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;  in_valid = 1'b0;
    #1;
    checks++; if ({out_valid, in_ready, redirect_valid, out_wen} !== 4'b0100) begin errors++; $display("[TB] FAIL midstall_reset: got v%b ready%b redir%b wen%b expected 0 1 0 0", out_valid, in_ready, redirect_valid, out_wen); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midstall_after: got %b expected 0", out_valid); end
  endtask

  // Random traffic: every delivered result must equal in-order execution over
  // the architectural registers. The bench acts as decode (register file with
  // write-through) and as the memory/writeback path returning results a cycle later.
  task automatic test_random();
    logic        pendWen;
    logic [4:0]  pendRd;
    logic [31:0] pendData;
    logic [31:0] a, b;
    logic [2:0]  ctl;
    expEntry_t   e;
    expEntry_t   got;
    pendWen = 1'b0;  pendRd = 5'd0;  pendData = 32'd0;
    archRf[0] = 32'd0;  physRf[0] = 32'd0;
    for (int r = 1; r < 32; r++) begin
      archRf[r] = $urandom;
      physRf[r] = archRf[r];
    end
    for (int cyc = 0; cyc < 440; cyc++) begin
      @(negedge clk);
      if (wb_wen) physRf[wb_rd] = wb_data;
      wb_wen = pendWen;  wb_rd = pendRd;  wb_data = pendData;
      pendWen = 1'b0;
      ctl = 3'($urandom_range(0, 5));
      if (ctl == 3'd5) ctl = 3'd7;
      applyStimulus(ctl, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    32'd0, 32'd0, $urandom, $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0));
      if (in_rs1 == 5'd0) in_rs1_val = $urandom;
      else in_rs1_val = (wb_wen && wb_rd == in_rs1) ? wb_data : physRf[in_rs1];
      if (in_rs2 == 5'd0) in_rs2_val = $urandom;
      else in_rs2_val = (wb_wen && wb_rd == in_rs2) ? wb_data : physRf[in_rs2];
      in_valid  = (cyc < 400) && ($urandom_range(0, 3) != 0);
      out_ready = (cyc >= 400) || ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) begin
        a = (in_rs1 == 5'd0) ? 32'd0 : archRf[in_rs1];
        b = in_use_imm ? in_imm : ((in_rs2 == 5'd0) ? 32'd0 : archRf[in_rs2]);
        e.result = aluRef(in_alu_ctl, a, b);
        e.rd     = in_rd;
        e.wen    = in_wen && (in_rd != 5'd0);
        expQ.push_back(e);
        if (e.wen) archRf[e.rd] = e.result;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL rand_unexpected: got %h rd%0d with nothing outstanding", out_result, out_rd);
        end else begin
          got = expQ.pop_front();
          if ({out_result, out_rd, out_wen} !== {got.result, got.rd, got.wen}) begin
            errors++;
            $display("[TB] FAIL rand_result cyc%0d: got %h rd%0d wen%b expected %h rd%0d wen%b",
                     cyc, out_result, out_rd, out_wen, got.result, got.rd, got.wen);
          end
        end
        pendWen = out_wen;  pendRd = out_rd;  pendData = out_result;
      end
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL rand_drain: got %0d results outstanding expected 0", expQ.size());
    end
    idleInputs();
  endtask

  // Runs every scenario in order, then prints the summary
  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    idleInputs();
    test_reset();
    test_add();
    test_back_to_back();
    test_stall();
    test_branch();
    test_flush();
    test_reset_midstall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guards against a hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
